stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Timekeeping stage directly downstream of the clock divider. It samples the divider's 10 kHz toggle output on the 25 MHz system clock and prescales it to a 1/100 s tick. It then runs a BCD mm:ss.cc stopwatch under start/stop, lap and clear commands. The BCD digit bus feeds the seven-segment display multiplexer and the Ethernet status reporter.

## Interface
Parameters:
- TICKS_PER_CS, 100, ten_khz_clk rising edges per centisecond (override to small values in simulation).
- MAX_MIN, 59, last minute value before wrap.

Ports:
- twentyFive_mhz_clk  input  1  system clock, 25 MHz.
- reset  input  1  asynchronous, active-high; clears all state.
- ten_khz_clk  input  1  10 kHz square wave from the divider, synchronous to twentyFive_mhz_clk.
- start_stop  input  1  single-cycle command pulse.
- lap  input  1  single-cycle command pulse.
- clear  input  1  single-cycle command pulse.
- disp_digits  output  24  BCD {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits each, MSB first.
- running  output  1  high in RUN.
- lap_hold  output  1  high while the display is frozen on a lap snapshot.
- cs_tick  output  1  one-cycle pulse on each centisecond advance.
- wrap  output  1  one-cycle pulse when time rolls from MAX_MIN:59.99 to 00:00.00.

## Operation
- Edge detect:
  - Registers tk_q1 (samples ten_khz_clk) and tk_q2 (samples tk_q1).
  - tk_rise = tk_q1 & ~tk_q2.
- Prescaler:
  - Runs 0..TICKS_PER_CS-1 and increments on tk_rise only in RUN.
  - It holds its value in PAUSE, so the sub-centisecond fraction is preserved.
  - It is zeroed by an accepted clear.
  - tk_rise at terminal count returns it to 0 and advances the time by 0.01 s.
- Time counter: six BCD digits chained by carry. Digit moduli:
  - cs_u /10, cs_t /10
  - sec_u /10, sec_t /6
  - min_u /10, min_t /6
  - Minutes stop at MAX_MIN.
  - The advance after MAX_MIN:59.99 gives 00:00.00, pulses wrap, and the block stays in RUN.
- FSM states IDLE, RUN, PAUSE:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN; clear -> IDLE.
  - clear in RUN is ignored.
  - clear in IDLE re-zeroes and stays in IDLE.
  - An accepted clear zeroes the time, the prescaler and lap_hold.
- Lap:
  - lap in RUN with lap_hold=0 captures the current time into a snapshot and sets lap_hold.
  - lap with lap_hold=1, in RUN or PAUSE, clears lap_hold.
  - lap in IDLE is ignored.
  - Counting continues underneath a held lap.
- disp_digits shows the snapshot when lap_hold=1, otherwise the live time.
- Simultaneous commands: priority is clear > start_stop > lap. Only the highest-priority pulse present is acted on; the others are dropped.
- Command and advance in the same cycle: state is evaluated using the pre-edge FSM state.
  - An advance coincident with start_stop in RUN still completes.
  - lap coincident with an advance snapshots the pre-advance time.

## Timing
- Reset values: disp_digits=24'h0, running=0, lap_hold=0, cs_tick=0, wrap=0. FSM=IDLE, prescaler=0, tk_q1=tk_q2=0.
- Latency from ten_khz_clk rising to output:
  - tk_q1 captures at edge N.
  - tk_rise is valid during cycle N.
  - Time registers, cs_tick and wrap update at edge N+1.
  - disp_digits reflects the new value at edge N+2.
- Command latency:
  - running changes at the first edge after the command pulse.
  - lap_hold and the snapshot update at that same edge.
  - disp_digits follows one edge later.
- Reset is asynchronous. Assertion mid-count forces the reset values immediately. Release is synchronous to the next clock edge.

## Structure
- Package stopwatch_pkg holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2).
  - BCD digit width (4).
  - Digit modulus constants (10, 6).
  - disp_digits nibble index constants.
- Sub-module bcd_digit_counter: one BCD digit with parameter MODULUS, inputs inc and clr, outputs digit and carry. It is instantiated six times with minutes limited via MAX_MIN. The FSM, prescaler and lap logic live in stopwatch_core.

## Test plan
- Reset and edge detect: assert reset mid-run at 00:03.47 -> all outputs 0 immediately. After release, 5 ten_khz_clk periods in IDLE -> disp_digits stays 24'h000000.
- Basic count (TICKS_PER_CS=2): start_stop, then 200 rising edges -> disp_digits=24'h000100 and cs_tick pulses 100 times. disp_digits updates exactly 2 cycles after the detected edge.
- Pause/resume preserves fraction (TICKS_PER_CS=4): start, 5 edges, stop, 10 edges, start, 3 edges -> 00:00.02.
- Lap: at 00:01.50 pulse lap -> disp frozen at 24'h000150 while counting continues. At live 00:02.20 pulse lap -> disp shows 24'h000220 one edge after lap_hold falls.
- Wrap: preload to 59:59.99 by running, then one more centisecond -> disp 24'h000000, one wrap pulse, running stays 1.
- Priority: clear+start_stop+lap in the same cycle in PAUSE -> IDLE, time zero, lap_hold=0. clear alone in RUN -> ignored, count continues.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings and constants for the mm:ss.cc stopwatch datapath.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2
   } sw_state_e;

   localparam int unsigned DigitW    = 4;
   localparam int unsigned NumDigits = 6;
   localparam int unsigned DispW     = DigitW * NumDigits;

   localparam int unsigned ModTen = 10;
   localparam int unsigned ModSix = 6;

   // Nibble positions inside disp_digits, counted from the LSB.
   localparam int unsigned IdxCsU  = 0;
   localparam int unsigned IdxCsT  = 1;
   localparam int unsigned IdxSecU = 2;
   localparam int unsigned IdxSecT = 3;
   localparam int unsigned IdxMinU = 4;
   localparam int unsigned IdxMinT = 5;

   function automatic int unsigned digit_modulus(input int unsigned idx);
      return (idx == IdxSecT || idx == IdxMinT) ? ModSix : ModTen;
   endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit_counter.sv
// One BCD digit: synchronous clear wins over increment, carry is combinational.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MODULUS = ModTen
) (
   input  logic              twentyFive_mhz_clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clr,
   output logic [DigitW-1:0] digit,
   output logic              carry
);

   localparam logic [DigitW-1:0] Last = DigitW'(MODULUS - 1);

   logic [DigitW-1:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = '0;
      end else if (inc) begin
         digit_d = (digit_q == Last) ? '0 : digit_q + 1'b1;
      end
   end

   always_ff @(posedge twentyFive_mhz_clk or posedge reset) begin
      if (reset) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   assign carry = inc & (digit_q == Last);

endmodule

// File: rtl/stopwatch_core.sv
// Centisecond prescaler, start/stop/lap/clear FSM and BCD mm:ss.cc time counter
// driven from the divider's 10 kHz output.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICKS_PER_CS = 100,
   parameter int unsigned MAX_MIN      = 59
) (
   input  logic             twentyFive_mhz_clk,
   input  logic             reset,
   input  logic             ten_khz_clk,
   input  logic             start_stop,
   input  logic             lap,
   input  logic             clear,
   output logic [DispW-1:0] disp_digits,
   output logic             running,
   output logic             lap_hold,
   output logic             cs_tick,
   output logic             wrap
);

   localparam int unsigned PrescW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
   localparam logic [PrescW-1:0] PrescLast = PrescW'(TICKS_PER_CS - 1);

   localparam logic [DigitW-1:0] MaxMinT = DigitW'(MAX_MIN / 10);
   localparam logic [DigitW-1:0] MaxMinU = DigitW'(MAX_MIN % 10);
   localparam logic [DispW-1:0]  MaxTime = {MaxMinT, MaxMinU, 4'd5, 4'd9, 4'd9, 4'd9};

   // Edge detect on the divider output
   logic tk_q1, tk_q2, tk_rise;

   always_ff @(posedge twentyFive_mhz_clk or posedge reset) begin
      if (reset) begin
         tk_q1 <= 1'b0;
         tk_q2 <= 1'b0;
      end else begin
         tk_q1 <= ten_khz_clk;
         tk_q2 <= tk_q1;
      end
   end

   assign tk_rise = tk_q1 & ~tk_q2;

   // Command priority: clear > start_stop > lap, lower ones dropped
   logic cmd_clear, cmd_ss, cmd_lap;

   assign cmd_clear = clear;
   assign cmd_ss    = start_stop & ~clear;
   assign cmd_lap   = lap & ~clear & ~start_stop;

   // FSM
   sw_state_e state_q, state_d;
   logic      in_run, clear_ok;

   assign in_run   = (state_q == StRun);
   assign clear_ok = cmd_clear & ~in_run;

   always_ff @(posedge twentyFive_mhz_clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (cmd_ss) state_d = StRun;
         end
         StRun: begin
            if (cmd_ss) state_d = StPause;
         end
         StPause: begin
            if (clear_ok) begin
               state_d = StIdle;
            end else if (cmd_ss) begin
               state_d = StRun;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      running = (state_q == StRun);
   end

   // Prescaler holds in PAUSE so the sub-centisecond fraction survives a stop
   logic [PrescW-1:0] presc_q, presc_d;
   logic              at_term, advance;

   assign at_term = (presc_q == PrescLast);
   assign advance = in_run & tk_rise & at_term;

   always_comb begin
      presc_d = presc_q;
      if (clear_ok) begin
         presc_d = '0;
      end else if (in_run && tk_rise) begin
         presc_d = at_term ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge twentyFive_mhz_clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // Time counter: carry chain of six digits, wrap clears all at MAX_MIN:59.99
   logic [DispW-1:0]   live_time;
   logic [NumDigits:0] inc_chain;
   logic               at_max, wrap_evt, time_clr;

   assign inc_chain[0] = advance;
   assign at_max       = (live_time == MaxTime);
   // The top carry can only fire at 59:59.99, which at_max already covers.
   assign wrap_evt     = (advance & at_max) | inc_chain[NumDigits];
   assign time_clr     = clear_ok | wrap_evt;

   for (genvar gi = 0; gi < NumDigits; gi++) begin : g_digit
      bcd_digit_counter #(
         .MODULUS (digit_modulus(gi))
      ) u_digit (
         .twentyFive_mhz_clk (twentyFive_mhz_clk),
         .reset              (reset),
         .inc                (inc_chain[gi]),
         .clr                (time_clr),
         .digit              (live_time[gi*DigitW +: DigitW]),
         .carry              (inc_chain[gi+1])
      );
   end

   // Lap snapshot captures the pre-advance time of the same cycle
   logic             lap_hold_q, lap_hold_d;
   logic [DispW-1:0] snap_q, snap_d;

   always_comb begin
      lap_hold_d = lap_hold_q;
      snap_d     = snap_q;
      if (clear_ok) begin
         lap_hold_d = 1'b0;
      end else if (cmd_lap) begin
         if (lap_hold_q) begin
            if (state_q != StIdle) lap_hold_d = 1'b0;
         end else if (in_run) begin
            lap_hold_d = 1'b1;
            snap_d     = live_time;
         end
      end
   end

   always_ff @(posedge twentyFive_mhz_clk or posedge reset) begin
      if (reset) begin
         lap_hold_q <= 1'b0;
         snap_q     <= '0;
      end else begin
         lap_hold_q <= lap_hold_d;
         snap_q     <= snap_d;
      end
   end

   // Registered outputs
   logic [DispW-1:0] disp_q;
   logic             cs_tick_q, wrap_q;

   always_ff @(posedge twentyFive_mhz_clk or posedge reset) begin
      if (reset) begin
         disp_q    <= '0;
         cs_tick_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         disp_q    <= lap_hold_q ? snap_q : live_time;
         cs_tick_q <= advance;
         wrap_q    <= wrap_evt;
      end
   end

   assign disp_digits = disp_q;
   assign lap_hold    = lap_hold_q;
   assign cs_tick     = cs_tick_q;
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: a behavioural time model queues each expected
// centisecond advance, and a monitor checks it against cs_tick / disp_digits / wrap.
module tb_stopwatch_core;

   localparam int unsigned TicksPerCs = 2;
   localparam int unsigned MaxMin     = 1;
   localparam int          MaxCs      = (MaxMin + 1) * 6000;
   localparam int          MIdle = 0, MRun = 1, MPause = 2;

   logic        sys_clk;
   logic        reset;
   logic        ten_khz_clk;
   logic        start_stop, lap, clear;
   logic [23:0] disp_digits;
   logic        running, lap_hold, cs_tick, wrap;

   stopwatch_core #(
      .TICKS_PER_CS (TicksPerCs),
      .MAX_MIN      (MaxMin)
   ) dut (
      .twentyFive_mhz_clk (sys_clk),
      .reset              (reset),
      .ten_khz_clk        (ten_khz_clk),
      .start_stop         (start_stop),
      .lap                (lap),
      .clear              (clear),
      .disp_digits        (disp_digits),
      .running            (running),
      .lap_hold           (lap_hold),
      .cs_tick            (cs_tick),
      .wrap               (wrap)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural model
   int          m_state, m_presc, m_time;
   logic        m_hold;
   logic [23:0] m_snap;

   function automatic logic [23:0] to_bcd(input int t);
      int mn, sc, cs;
      mn = t / 6000;
      sc = (t / 100) % 60;
      cs = t % 100;
      return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
   endfunction

   function automatic logic [23:0] exp_disp();
      return m_hold ? m_snap : to_bcd(m_time);
   endfunction

   task automatic model_reset();
      m_state = MIdle;
      m_presc = 0;
      m_time  = 0;
      m_hold  = 1'b0;
      m_snap  = '0;
   endtask

   task automatic model_cmd(input logic ss, input logic lp, input logic cl);
      if (cl) begin
         if (m_state != MRun) begin
            m_state = MIdle;
            m_time  = 0;
            m_presc = 0;
            m_hold  = 1'b0;
         end
      end else if (ss) begin
         m_state = (m_state == MRun) ? MPause : MRun;
      end else if (lp) begin
         if (m_hold) begin
            if (m_state != MIdle) m_hold = 1'b0;
         end else if (m_state == MRun) begin
            m_hold = 1'b1;
            m_snap = to_bcd(m_time);
         end
      end
   endtask

   // Scoreboard
   typedef struct packed {
      logic [23:0] old_d;
      logic [23:0] new_d;
      logic        wr;
   } sb_item_t;

   sb_item_t sb_q[$];
   int       tick_cnt = 0;
   int       wrap_cnt = 0;

   always @(negedge sys_clk) begin
      if (!reset && wrap) wrap_cnt++;
      if (!reset && cs_tick) begin
         sb_item_t it;
         tick_cnt++;
         if (sb_q.size() == 0) begin
            check_eq("tick_unexpected", 32'd1, 32'd0);
         end else begin
            it = sb_q.pop_front();
            check_eq("tick_old_disp", disp_digits, it.old_d);
            check_eq("tick_wrap", wrap, it.wr);
            @(negedge sys_clk);
            check_eq("tick_new_disp", disp_digits, it.new_d);
         end
      end
   end

   // Stimulus
   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic tk_edge();
      sb_item_t it;
      @(negedge sys_clk);
      ten_khz_clk = 1'b1;
      if (m_state == MRun) begin
         if (m_presc == TicksPerCs - 1) begin
            it.old_d = exp_disp();
            m_presc  = 0;
            m_time   = (m_time + 1) % MaxCs;
            it.wr    = (m_time == 0);
            it.new_d = exp_disp();
            sb_q.push_back(it);
         end else begin
            m_presc++;
         end
      end
      @(negedge sys_clk);
      ten_khz_clk = 1'b0;
   endtask

   task automatic cmd(input logic ss, input logic lp, input logic cl);
      @(negedge sys_clk);
      start_stop = ss;
      lap        = lp;
      clear      = cl;
      @(negedge sys_clk);
      start_stop = 1'b0;
      lap        = 1'b0;
      clear      = 1'b0;
      model_cmd(ss, lp, cl);
      check_eq("cmd_running", running, (m_state == MRun));
      check_eq("cmd_lap_hold", lap_hold, m_hold);
      @(negedge sys_clk);
      check_eq("cmd_disp", disp_digits, exp_disp());
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tick_base, wrap_base;
      reset       = 1'b1;
      ten_khz_clk = 1'b0;
      start_stop  = 1'b0;
      lap         = 1'b0;
      clear       = 1'b0;
      model_reset();
      idle(3);
      check_eq("rst_disp", disp_digits, 24'h000000);
      check_eq("rst_flags", {running, lap_hold, cs_tick, wrap}, 4'b0000);
      reset = 1'b0;
      idle(2);

      // Basic count
      cmd(1'b1, 1'b0, 1'b0);
      tick_base = tick_cnt;
      repeat (200) tk_edge();
      idle(3);
      check_eq("basic_disp", disp_digits, 24'h000100);
      check_eq("basic_ticks", tick_cnt - tick_base, 32'd100);

      // Pause keeps the prescaler fraction
      cmd(1'b1, 1'b0, 1'b0);
      cmd(1'b0, 1'b0, 1'b1);
      check_eq("clr_pause_disp", disp_digits, 24'h000000);
      cmd(1'b1, 1'b0, 1'b0);
      repeat (5) tk_edge();
      cmd(1'b1, 1'b0, 1'b0);
      repeat (10) tk_edge();
      cmd(1'b1, 1'b0, 1'b0);
      repeat (3) tk_edge();
      idle(3);
      check_eq("pause_frac", disp_digits, 24'h000004);

      // Lap freeze and release
      while (m_time < 150) tk_edge();
      idle(3);
      cmd(1'b0, 1'b1, 1'b0);
      check_eq("lap_frozen", disp_digits, 24'h000150);
      while (m_time < 220) tk_edge();
      idle(3);
      check_eq("lap_still_frozen", disp_digits, 24'h000150);
      cmd(1'b0, 1'b1, 1'b0);
      check_eq("lap_release_disp", disp_digits, 24'h000220);

      // All three commands in PAUSE with a held lap
      cmd(1'b0, 1'b1, 1'b0);
      cmd(1'b1, 1'b0, 1'b0);
      check_eq("pause_hold_kept", lap_hold, 1'b1);
      cmd(1'b1, 1'b1, 1'b1);
      check_eq("prio_running", running, 1'b0);
      check_eq("prio_lap_hold", lap_hold, 1'b0);
      check_eq("prio_disp", disp_digits, 24'h000000);

      // clear ignored in RUN
      cmd(1'b1, 1'b0, 1'b0);
      repeat (20) tk_edge();
      cmd(1'b0, 1'b0, 1'b1);
      check_eq("clr_run_ignored", running, 1'b1);
      repeat (20) tk_edge();
      idle(3);
      check_eq("clr_run_count", disp_digits, 24'h000020);

      // Wrap at MAX_MIN:59.99
      while (m_time != MaxCs - 1) tk_edge();
      idle(3);
      check_eq("pre_wrap_disp", disp_digits, 24'h015999);
      wrap_base = wrap_cnt;
      while (m_time != 0) tk_edge();
      idle(3);
      check_eq("wrap_disp", disp_digits, 24'h000000);
      check_eq("wrap_pulses", wrap_cnt - wrap_base, 32'd1);
      check_eq("wrap_running", running, 1'b1);

      // Asynchronous reset mid-run
      while (m_time != 347) tk_edge();
      idle(3);
      check_eq("pre_rst_disp", disp_digits, 24'h000347);
      @(negedge sys_clk);
      #3 reset = 1'b1;
      #1;
      check_eq("async_rst_disp", disp_digits, 24'h000000);
      check_eq("async_rst_flags", {running, lap_hold, cs_tick, wrap}, 4'b0000);
      model_reset();
      idle(2);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tk_edge();
         check_eq("idle_disp", disp_digits, 24'h000000);
      end
      idle(3);
      check_eq("idle_disp_end", disp_digits, 24'h000000);
      check_eq("idle_running", running, 1'b0);
      check_eq("sb_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
